// File: rtl/memory_port_arbiter.sv
// ============================================================================
// Module : memory_port_arbiter
// Brief  : Shares one memory port between the CPU and a data-break requester.
//          Define BRK_PRIORITY_EN for fixed data-break priority.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module memory_port_arbiter #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 12,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              brk_rd,
  input  logic              brk_wr,
  input  logic [ADDR_W-1:0] brk_addr,
  input  logic [DATA_W-1:0] brk_wdata,
  output logic              brk_done,
  output logic [DATA_W-1:0] brk_rdata,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_finished,
  output logic              timeout_err,
  output logic              last_grant
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              op_wr;
  logic              abort;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] cap_rdata;

  logic cpu_req;
  logic brk_req;
  logic grant_brk;
  logic win_wr;
  logic expired;

  assign cpu_req = cpu_rd | cpu_wr;
  assign brk_req = brk_rd | brk_wr;
`ifdef BRK_PRIORITY_EN
  assign grant_brk = brk_req;
`else
  // Round-robin: on contention the side that was not served last wins.
  assign grant_brk = brk_req & (~cpu_req | ~last_grant);
`endif
  // Write takes precedence when a requester raises both rd and wr.
  assign win_wr  = grant_brk ? brk_wr : cpu_wr;
  assign expired = (cnt == CNT_LAST);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cpu_req || brk_req) state_next = BUSY;
      BUSY:    if (mem_finished || expired) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      op_wr      <= 1'b0;
      abort      <= 1'b0;
      cnt        <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      cap_rdata  <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (cpu_req || brk_req) begin
            last_grant <= grant_brk;
            op_wr      <= win_wr;
            lat_addr   <= grant_brk ? brk_addr  : cpu_addr;
            lat_wdata  <= grant_brk ? brk_wdata : cpu_wdata;
            cnt        <= '0;
            abort      <= 1'b0;
            cap_rdata  <= '0;
          end
        end
        BUSY: begin
          if (mem_finished) begin
            cap_rdata <= op_wr ? '0 : mem_rdata;
          end else if (expired) begin
            abort     <= 1'b1;
            cap_rdata <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes decode straight from state so they fall on the same edge that leaves BUSY.
  assign mem_read_en  = (state == BUSY) & ~op_wr;
  assign mem_write_en = (state == BUSY) &  op_wr;
  assign mem_addr     = lat_addr;
  assign mem_wdata    = lat_wdata;

  assign cpu_done    = (state == DONE) & ~last_grant;
  assign brk_done    = (state == DONE) &  last_grant;
  assign cpu_rdata   = cpu_done ? cap_rdata : '0;
  assign brk_rdata   = brk_done ? cap_rdata : '0;
  assign timeout_err = (state == DONE) & abort;

endmodule

`default_nettype wire

// File: tb/tb_memory_port_arbiter.sv
// ============================================================================
// Module : tb_memory_port_arbiter
// Brief  : Directed vector bench for memory_port_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_memory_port_arbiter;

  localparam int ADDR_W      = 12;
  localparam int DATA_W      = 12;
  localparam int TIMEOUT_CYC = 64;
`ifdef BRK_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              resetN;
  logic              cpu_rd, cpu_wr, brk_rd, brk_wr;
  logic [ADDR_W-1:0] cpu_addr, brk_addr, mem_addr;
  logic [DATA_W-1:0] cpu_wdata, brk_wdata, mem_wdata, mem_rdata;
  logic [DATA_W-1:0] cpu_rdata, brk_rdata;
  logic              cpu_done, brk_done, mem_read_en, mem_write_en;
  logic              mem_finished, timeout_err, last_grant;

  always #5 clock = ~clock;

  memory_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clock(clock), .resetN(resetN),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .brk_rd(brk_rd), .brk_wr(brk_wr), .brk_addr(brk_addr), .brk_wdata(brk_wdata),
    .brk_done(brk_done), .brk_rdata(brk_rdata),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_finished(mem_finished), .timeout_err(timeout_err), .last_grant(last_grant)
  );

  typedef struct {
    logic              c_rd, c_wr, b_rd, b_wr;
    logic [ADDR_W-1:0] c_addr, b_addr;
    logic [DATA_W-1:0] c_wdata, b_wdata, m_rdata;
    int                fin;
    logic              e_grant, e_wr;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata, e_rdata;
  } txn_t;

  txn_t vecs[5];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic idle_inputs();
    cpu_rd = 0; cpu_wr = 0; brk_rd = 0; brk_wr = 0;
    cpu_addr = '0; brk_addr = '0; cpu_wdata = '0; brk_wdata = '0;
    mem_rdata = '0; mem_finished = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_en"}, mem_read_en, 0);
    check({tag, "_wr_en"}, mem_write_en, 0);
    check({tag, "_cpu_done"}, cpu_done, 0);
    check({tag, "_brk_done"}, brk_done, 0);
    check({tag, "_terr"}, timeout_err, 0);
  endtask

  task automatic run_txn(input txn_t v, input int idx);
    @(negedge clock);
    cpu_rd = v.c_rd; cpu_wr = v.c_wr; cpu_addr = v.c_addr; cpu_wdata = v.c_wdata;
    brk_rd = v.b_rd; brk_wr = v.b_wr; brk_addr = v.b_addr; brk_wdata = v.b_wdata;
    @(negedge clock);
    for (int c = 1; c <= v.fin; c++) begin
      if (c > 1) @(negedge clock);
      check($sformatf("v%0d_rd_en_c%0d", idx, c), mem_read_en, !v.e_wr);
      check($sformatf("v%0d_wr_en_c%0d", idx, c), mem_write_en, v.e_wr);
      check($sformatf("v%0d_addr_c%0d", idx, c), mem_addr, v.e_addr);
      check($sformatf("v%0d_wdata_c%0d", idx, c), mem_wdata, v.e_wdata);
      if (c == 1) begin
        check($sformatf("v%0d_grant", idx), last_grant, v.e_grant);
        // Requester fields wiggle during BUSY; the latched values must hold.
        cpu_addr = 12'o7777; brk_addr = 12'o6666; cpu_wdata = 12'o5555; brk_wdata = 12'o4444;
      end
      if (c == v.fin) begin
        mem_finished = 1; mem_rdata = v.m_rdata;
      end
    end
    @(negedge clock);
    mem_finished = 0; mem_rdata = 12'o3333;
    cpu_rd = 0; cpu_wr = 0; brk_rd = 0; brk_wr = 0;
    check($sformatf("v%0d_strobes_off", idx), {mem_read_en, mem_write_en}, 0);
    check($sformatf("v%0d_cpu_done", idx), cpu_done, !v.e_grant);
    check($sformatf("v%0d_brk_done", idx), brk_done, v.e_grant);
    check($sformatf("v%0d_cpu_rdata", idx), cpu_rdata, v.e_grant ? '0 : v.e_rdata);
    check($sformatf("v%0d_brk_rdata", idx), brk_rdata, v.e_grant ? v.e_rdata : '0);
    check($sformatf("v%0d_terr", idx), timeout_err, 0);
    @(negedge clock);
    check_idle_outputs($sformatf("v%0d_after", idx));
  endtask

  initial begin
    // {c_rd,c_wr,b_rd,b_wr, c_addr,b_addr, c_wdata,b_wdata,m_rdata, fin, e_grant,e_wr, e_addr,e_wdata,e_rdata}
    vecs[0] = '{1,0,0,0, 12'o0200,12'o0000, 12'o0000,12'o0000,12'o7300, 3, 0,0, 12'o0200,12'o0000,12'o7300};
    vecs[1] = '{0,1,0,0, 12'o0017,12'o0000, 12'o1234,12'o0000,12'o4321, 2, 0,1, 12'o0017,12'o1234,12'o0000};
    vecs[2] = '{0,0,1,0, 12'o0000,12'o4000, 12'o0000,12'o0000,12'o0123, 1, 1,0, 12'o4000,12'o0000,12'o0123};
    vecs[3] = '{0,0,1,1, 12'o0000,12'o0377, 12'o0000,12'o7777,12'o2525, 4, 1,1, 12'o0377,12'o7777,12'o0000};
    vecs[4] = '{1,1,0,0, 12'o1111,12'o0000, 12'o2222,12'o0000,12'o1357, 1, 0,1, 12'o1111,12'o2222,12'o0000};

    idle_inputs();
    resetN = 0;
    repeat (2) @(negedge clock);
    check_idle_outputs("rst");
    check("rst_grant", last_grant, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_rdata", {cpu_rdata, brk_rdata}, 0);
    resetN = 1;

    for (int i = 0; i < 5; i++) run_txn(vecs[i], i);

    // Contention straight after reset, both sides holding their requests.
    @(negedge clock);
    resetN = 0;
    @(negedge clock);
    resetN = 1;
    cpu_rd = 1; brk_rd = 1; cpu_addr = 12'o0100; brk_addr = 12'o0200;
    @(negedge clock);
    for (int g = 0; g < 4; g++) begin
      logic eg;
      eg = PRIO ? 1'b1 : ((g % 2) == 0);
      check($sformatf("rr%0d_rd_en", g), mem_read_en, 1);
      check($sformatf("rr%0d_grant", g), last_grant, eg);
      check($sformatf("rr%0d_addr", g), mem_addr, eg ? 12'o0200 : 12'o0100);
      mem_finished = 1; mem_rdata = 12'(12'o0100 + g);
      @(negedge clock);
      mem_finished = 0;
      check($sformatf("rr%0d_cpu_done", g), cpu_done, !eg);
      check($sformatf("rr%0d_brk_done", g), brk_done, eg);
      check($sformatf("rr%0d_rdata", g), eg ? brk_rdata : cpu_rdata, 12'(12'o0100 + g));
      @(negedge clock);
      check($sformatf("rr%0d_idle_gap", g), mem_read_en, 0);
      @(negedge clock);
    end
    @(negedge clock);
    cpu_rd = 0; brk_rd = 0;
    mem_finished = 1;
    @(negedge clock);
    mem_finished = 0;
    @(negedge clock);
    check_idle_outputs("rr_end");

    // Timeout: memory never answers.
    cpu_rd = 1; cpu_addr = 12'o0050; mem_rdata = 12'o7070;
    @(negedge clock);
    begin
      int busy_cyc = 0;
      for (int i = 0; i < 200 && mem_read_en; i++) begin
        busy_cyc++;
        @(negedge clock);
      end
      check("to_busy_cycles", busy_cyc, TIMEOUT_CYC);
    end
    cpu_rd = 0;
    check("to_cpu_done", cpu_done, 1);
    check("to_terr", timeout_err, 1);
    check("to_rdata", cpu_rdata, 0);
    check("to_brk_done", brk_done, 0);
    @(negedge clock);
    check_idle_outputs("to_after");

    // Reset in the middle of a transfer, request kept high throughout.
    cpu_rd = 1; cpu_addr = 12'o0444;
    @(negedge clock);
    @(negedge clock);
    check("rb_busy", mem_read_en, 1);
    resetN = 0;
    #1;
    check("rb_strobe_drop", mem_read_en, 0);
    check("rb_grant", last_grant, 0);
    @(negedge clock);
    check("rb_no_done", cpu_done, 0);
    resetN = 1;
    @(negedge clock);
    check("rb_regrant", mem_read_en, 1);
    check("rb_addr", mem_addr, 12'o0444);
    mem_finished = 1; mem_rdata = 12'o0606;
    @(negedge clock);
    mem_finished = 0; cpu_rd = 0;
    check("rb_done", cpu_done, 1);
    check("rb_rdata", cpu_rdata, 12'o0606);
    @(negedge clock);
    check_idle_outputs("rb_after");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
